encoder_8_to_3_serial: RTL and testbench
========================================

Name: encoder_8_to_3_serial

Overview:
- Converse of the 3-to-8 decoder: accepts an 8-bit multi-hot vector and emits the 3-bit index of every set bit, one index per handshake, highest priority first.
- Serialises interrupt/request vectors into an index stream for downstream index-consuming logic.
- Valid/ready on both sides.
- No combinational path from in_vec to the output port; all outputs derive from registers.

Parameters:
- N, 8, input vector width (fixed at 8 for this block; kept for package consistency).
- W, 3, index width, equals clog2(N).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  in_vec is presented
- in_ready  output  1  block can accept a vector
- in_vec  input  8  request vector, any number of bits set
- out_valid  output  1  out_idx, out_last and out_none are valid
- out_ready  input  1  consumer accepts the current index
- out_idx  output  3  encoded bit index
- out_last  output  1  final index of the current vector
- out_none  output  1  accepted vector was all-zero

Behaviour:
- Reset: clk edge sampling rst_n=0 sets the following:
  - state=IDLE, pend=8'h00, zero_flag=0.
  - Outputs: out_valid=0, out_idx=0, out_last=0, out_none=0.
  - in_ready=0 while rst_n is low.
- Reset mid-EMIT discards all pending bits; no further out_valid.
- States: IDLE, EMIT.
- in_ready=1 only in IDLE with rst_n=1.
- Accept: in_valid&&in_ready at edge k.
  - pend<=in_vec, zero_flag<=(in_vec==0), state<=EMIT.
  - out_valid is high in the cycle after edge k (latency 1).
- EMIT outputs, derived from pend only:
  - out_valid=1.
  - out_idx = index of the highest set bit of pend (MSB-first).
  - out_last = exactly one bit set in pend, or zero_flag.
  - out_none = zero_flag; when set, out_idx=0 and out_last=1.
- Transfer: out_valid&&out_ready at an edge clears the emitted bit in pend.
  - If out_last: state<=IDLE, pend<=0, zero_flag<=0.
- out_ready low holds out_idx/out_last/out_none stable. Required; checked by assertion.
- No new vector is accepted during EMIT (in_ready=0).
  - Throughput: popcount(vec) transfer cycles (1 for zero vector) plus 1 IDLE cycle per vector.
- in_valid while in_ready=0 is ignored; the source must hold it.
- in_vec=8'hFF emits 7,6,5,4,3,2,1,0; out_last is set on 0.
- Index arithmetic is unsigned 3-bit; no wrap possible.

Optional Feature:
- Macro: ENC_LSB_FIRST_EN.
- Defined: priority inverts; out_idx = lowest set bit of pend, so the emission order is ascending.
- Undefined: MSB-first as above.
- Handshake, latency and out_last/out_none rules are identical in both builds.

Decomposition:
- Package encoder_pkg holds:
  - localparams N=8, W=3.
  - typedef enum logic state_t {IDLE, EMIT}.
  - typedef logic [N-1:0] vec_t and logic [W-1:0] idx_t.
- Sub-module priority_index_8: purely combinational find-first-set over vec_t.
  - Outputs idx_t and a one_hot_or_zero flag (popcount<=1).
  - Direction selected by ENC_LSB_FIRST_EN.
  - Instantiated once on pend.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> during reset in_ready=0 and out_valid=0; first cycle after release in_ready=1.
- Single hot: in_vec=8'b0010_0000 with out_ready=1 -> next cycle out_valid=1, out_idx=5, out_last=1; following cycle in_ready=1.
- Multi-hot with backpressure:
  - Stimulus: in_vec=8'b1001_0010, out_ready toggling 1,0,0,1,1.
  - Response: indices 7,4,1 in order; each held stable while out_ready=0; out_last only on 1.
- Zero vector: in_vec=8'h00 -> one transfer with out_none=1, out_idx=0, out_last=1; then IDLE.
- Full vector and ignore rule: in_vec=8'hFF -> 8 transfers, 7 down to 0 (0 up to 7 with ENC_LSB_FIRST_EN); in_valid held during EMIT is not accepted.
- Mid-operation reset: in_vec=8'hF0, reset asserted after 2 transfers -> out_valid=0 next cycle; after release in_ready=1 and no residual indices 5 or 4 are emitted.

Source files
------------

// File: rtl/encoder_8_to_3_serial_pkg.sv
// Shared types for the serial 8-to-3 index encoder.
// The optional ENC_LSB_FIRST_EN build macro is consumed by priority_index_8.
package encoder_pkg;

    localparam int N = 8;
    localparam int W = 3;

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    typedef logic [N-1:0] vec_t;
    typedef logic [W-1:0] idx_t;

endpackage

// File: rtl/encoder_8_to_3_serial_priority_index_8.sv
// Combinational find-first-set over an 8-bit vector plus a popcount<=1 flag.
// Define ENC_LSB_FIRST_EN to pick the lowest set bit instead of the highest.
module priority_index_8
    import encoder_pkg::*;
(
    input  logic [7:0] i_vec,
    output logic [2:0] o_idx,
    output logic       o_one_hot_or_zero
);

    idx_t w_idx;

    always_comb begin
        w_idx = '0;
`ifdef ENC_LSB_FIRST_EN
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) w_idx = idx_t'(i);
        end
`else
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) w_idx = idx_t'(i);
        end
`endif
    end

    assign o_idx             = w_idx;
    assign o_one_hot_or_zero = ((i_vec & (i_vec - 8'd1)) == 8'd0);

endmodule

// File: rtl/encoder_8_to_3_serial.sv
// Serialises a multi-hot request vector into one index per output handshake.
// Order is MSB-first by default; ENC_LSB_FIRST_EN selects ascending order.
module encoder_8_to_3_serial
    import encoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic       out_none
);

    state_t r_state;
    vec_t   r_pend;
    logic   r_zero_flag;

    idx_t   w_idx;
    logic   w_one_hot_or_zero;
    logic   w_emit;
    logic   w_last;

    priority_index_8 u_prio (
        .i_vec             (r_pend),
        .o_idx             (w_idx),
        .o_one_hot_or_zero (w_one_hot_or_zero)
    );

    // Outputs depend only on registered state, never on in_vec.
    assign w_emit    = (r_state == EMIT);
    assign w_last    = w_emit && (r_zero_flag || w_one_hot_or_zero);
    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = w_emit;
    assign out_idx   = (w_emit && !r_zero_flag) ? w_idx : '0;
    assign out_last  = w_last;
    assign out_none  = w_emit && r_zero_flag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pend      <= '0;
            r_zero_flag <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pend      <= in_vec;
                        r_zero_flag <= (in_vec == 8'd0);
                        r_state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (w_last) begin
                            r_state     <= IDLE;
                            r_pend      <= '0;
                            r_zero_flag <= 1'b0;
                        end else begin
                            r_pend[w_idx] <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8_to_3_serial.sv
// Directed plus randomized bench for encoder_8_to_3_serial against a list-based model.
// Honors ENC_LSB_FIRST_EN to flip the expected emission order.
module tb_encoder_8_to_3_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_none;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q_idx[$];
    logic [7:0] q_last[$];
    logic [7:0] q_none[$];
    bit         pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    encoder_8_to_3_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: list every set bit index in priority order; zero vector yields one "none" entry.
    task automatic build(input logic [7:0] v);
        q_idx.delete(); q_last.delete(); q_none.delete();
        if (v == 8'd0) begin
            q_idx.push_back(8'd0); q_last.push_back(8'd1); q_none.push_back(8'd1);
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    q_idx.push_back(8'(i)); q_last.push_back(8'd0); q_none.push_back(8'd0);
                end
            end
`ifdef ENC_LSB_FIRST_EN
            q_idx.reverse();
`endif
            q_last[q_last.size()-1] = 8'd1;
        end
    endtask

    // mode 0: always ready, 1: fixed 1,0,0,1,1 pattern, 2: random ready plus in_valid held high.
    task automatic run_vec(input logic [7:0] v, input int mode, input int limit);
        int k;
        int cyc;
        bit rdy;
        k = 0;
        cyc = 0;
        build(v);
        @(negedge clk);
        chk("in_ready_idle", 8'(in_ready), 8'd1);
        in_valid  = 1'b1;
        in_vec    = v;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        while (k < q_idx.size() && k < limit && cyc < 200) begin
            chk("out_valid", 8'(out_valid), 8'd1);
            chk("out_idx",   8'(out_idx),   q_idx[k]);
            chk("out_last",  8'(out_last),  q_last[k]);
            chk("out_none",  8'(out_none),  q_none[k]);
            chk("in_ready_emit", 8'(in_ready), 8'd0);
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = pat[cyc % 5];
            else                rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            if (mode == 2) begin
                in_valid = !(rdy && q_last[k] == 8'd1);
                in_vec   = 8'($urandom);
            end
            if (rdy) k++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (cyc >= 200) chk("drain_timeout", 8'(k), 8'(q_idx.size()));
        if (k == q_idx.size()) begin
            chk("out_valid_done", 8'(out_valid), 8'd0);
            chk("in_ready_done",  8'(in_ready),  8'd1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'd0;
        out_ready = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready",  8'(in_ready),  8'd0);
            chk("rst_out_valid", 8'(out_valid), 8'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready",  8'(in_ready),  8'd1);
        chk("post_rst_out_valid", 8'(out_valid), 8'd0);
        chk("post_rst_out_idx",   8'(out_idx),   8'd0);
        chk("post_rst_out_last",  8'(out_last),  8'd0);
        chk("post_rst_out_none",  8'(out_none),  8'd0);

        run_vec(8'b0010_0000, 0, 99);
        run_vec(8'b1001_0010, 1, 99);
        run_vec(8'h00, 0, 99);
        run_vec(8'hFF, 2, 99);

        // Reset after two transfers must drop everything still pending.
        run_vec(8'hF0, 0, 2);
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 8'(out_valid), 8'd0);
        chk("midrst_in_ready",  8'(in_ready),  8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rel_in_ready", 8'(in_ready), 8'd1);
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_residual", 8'(out_valid), 8'd0);
        end
        out_ready = 1'b0;

        repeat (25) run_vec(8'($urandom), 2, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
